// File: rtl/fx_sqrt_arbiter.sv
// fx_sqrt_arbiter: shares one fxSqrt instance between N_REQ requesters.
//
// Issue side picks one valid requester round-robin and forwards its operand to the fxSqrt
// valid/ready input with no added latency. Each accepted operand pushes its requester ID into
// a tag FIFO; because fxSqrt returns results in order, the FIFO head names the owner of the
// result currently presented on the fxSqrt output, which is steered back to that requester.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready/a   per-requester operand handshake; operand i at req_a[i*WIDTH +: WIDTH]
//   rsp_valid/ready     per-requester result handshake
//   rsp_result          result word, broadcast, qualified by rsp_valid
//   sq_valid/ready/a    to/from fxSqrt input port
//   sq_res_valid/ready  to/from fxSqrt output port
//   sq_result           fxSqrt result word
//   inflight            tag FIFO occupancy
//   err_orphan          sticky: a result showed up with no operand outstanding

module fx_sqrt_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ*WIDTH-1:0]            req_a,
  output logic [N_REQ-1:0]                  rsp_valid,
  input  logic [N_REQ-1:0]                  rsp_ready,
  output logic [WIDTH-1:0]                  rsp_result,
  output logic                              sq_valid,
  input  logic                              sq_ready,
  output logic [WIDTH-1:0]                  sq_a,
  input  logic                              sq_res_valid,
  output logic                              sq_res_ready,
  input  logic [WIDTH-1:0]                  sq_result,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_orphan
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT+1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_orphan_q, err_orphan_d;
  logic [ID_W-1:0]  tag_mem_q [MAX_INFLIGHT];
  logic [ID_W-1:0]  tag_mem_d [MAX_INFLIGHT];

  logic [WIDTH-1:0] req_a_arr [N_REQ];
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  idx;
  logic [31:0]      idx_full;
  logic             found;
  logic             any_valid;
  logic             full;
  logic             empty;
  logic             issue_ok;
  logic             issue;
  logic             retire;
  logic [ID_W-1:0]  head;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
  end

  assign full      = (count_q == CNT_W'(MAX_INFLIGHT));
  assign empty     = (count_q == '0);
  assign any_valid = |req_valid;
  assign head      = tag_mem_q[rd_ptr_q];

  // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    idx      = '0;
    idx_full = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_full = 32'(rr_ptr_q) + k;
      if (idx_full >= N_REQ) idx_full = idx_full - N_REQ;
      idx = ID_W'(idx_full);
      if (!found && req_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Outputs are forced low while rst_n is asserted so the reset cycle is fully quiet.
  always_comb begin
    issue_ok = rst_n && any_valid && !full;
    sq_valid = issue_ok;
    sq_a     = req_a_arr[grant];
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = issue_ok && sq_ready && (grant == ID_W'(i));
    end
    issue = issue_ok && sq_ready;
  end

  // Response steering depends only on FIFO state and the fxSqrt/rsp_ready inputs.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = rst_n && sq_res_valid && !empty && (head == ID_W'(i));
    end
    rsp_result   = sq_result;
    sq_res_ready = rst_n && !empty && rsp_ready[head];
    retire       = sq_res_valid && sq_res_ready;
    inflight     = rst_n ? count_q : '0;
    err_orphan   = rst_n && err_orphan_q;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    tag_mem_d    = tag_mem_q;
    err_orphan_d = err_orphan_q | (sq_res_valid && empty);

    if (issue) begin
      tag_mem_d[wr_ptr_q] = grant;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      rr_ptr_d            = (grant == ID_W'(N_REQ-1)) ? '0 : grant + ID_W'(1);
    end
    if (retire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({issue, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Tag storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

endmodule

// File: tb/tb_fx_sqrt_arbiter.sv
// Bench for fx_sqrt_arbiter: directed phases plus a random phase. The bench plays the fxSqrt
// (fixed-latency, stall-stable, Q16.16 integer sqrt) and keeps an issue-ordered list of
// outstanding operands as the reference for arbitration, routing and occupancy.

module tb_fx_sqrt_arbiter;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int MAXI = 16;
  localparam int LAT  = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a;
  logic [W-1:0] rsp_result, sq_a, sq_result;
  logic         sq_valid, sq_ready, sq_res_valid, sq_res_ready;
  logic [4:0]   inflight;
  logic         err_orphan;

  fx_sqrt_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .sq_valid(sq_valid), .sq_ready(sq_ready), .sq_a(sq_a),
    .sq_res_valid(sq_res_valid), .sq_res_ready(sq_res_ready), .sq_result(sq_result),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [31:0] a;
  } ent_t;

  ent_t        pend_q[$];      // outstanding operands in issue order
  logic [31:0] pipe_res[$];    // fxSqrt model contents
  int          pipe_age[$];
  logic [31:0] op [N];
  int          grant_log[$];
  int          rr;
  bit          orphan_exp;
  bit          refresh;
  int          compared, mismatched;
  int          tot_iss, tot_del;
  int          rsp_cnt [N];
  logic [N-1:0] obs_req_ready, obs_rsp_valid;
  logic [W-1:0] obs_rsp_result;
  logic [4:0]   obs_inflight;
  logic         obs_sq_valid, obs_sq_res_ready, obs_err_orphan;

  function automatic logic [31:0] isqrt_q16(logic [31:0] a);
    logic [63:0] v, r, b;
    v = {16'h0, a, 16'h0};
    r = '0;
    for (int i = 23; i >= 0; i--) begin
      b = r | (64'd1 << i);
      if (b * b <= v) r = b;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] rand_op();
    return 32'($urandom_range(0, 32'h00FF_FFFF));
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sqrt(string tag, logic [31:0] obs, logic [31:0] a);
    real e, d;
    e = $sqrt(real'(a)) * 256.0;
    d = real'(obs) - e;
    compared++;
    assert (d <= 1.0 && d >= -1.0) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h(+-1)", tag, obs, $rtoi(e));
    end
  endtask

  // One clock cycle: check DUT against the reference, advance the models, set up next cycle.
  task automatic tick();
    logic [N-1:0] exp_rr, exp_rv;
    bit   any, full, empty, exp_sv, exp_srr;
    int   g, head_id;
    ent_t e;
    for (int i = 0; i < N; i++) req_a[i*W +: W] = op[i];
    #1;
    any   = |req_valid;
    full  = (pend_q.size() == MAXI);
    empty = (pend_q.size() == 0);
    head_id = empty ? 0 : pend_q[0].id;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
    end
    exp_sv  = rst_n && any && !full;
    exp_rr  = (exp_sv && sq_ready) ? (N'(1) << g) : '0;
    exp_rv  = (rst_n && sq_res_valid && !empty) ? (N'(1) << head_id) : '0;
    exp_srr = rst_n && !empty && rsp_ready[head_id];

    obs_req_ready = req_ready;   obs_rsp_valid = rsp_valid;   obs_rsp_result = rsp_result;
    obs_inflight  = inflight;    obs_sq_valid  = sq_valid;    obs_sq_res_ready = sq_res_ready;
    obs_err_orphan = err_orphan;

    chk("sq_valid", 64'(sq_valid), 64'(exp_sv));
    chk("req_ready", 64'(req_ready), 64'(exp_rr));
    if (exp_sv) chk("sq_a", 64'(sq_a), 64'(op[g]));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("sq_res_ready", 64'(sq_res_ready), 64'(exp_srr));
    chk("inflight", 64'(inflight), 64'(rst_n ? pend_q.size() : 0));
    chk("err_orphan", 64'(err_orphan), 64'(rst_n && orphan_exp));
    if (rsp_valid != '0) chk("rsp_result", 64'(rsp_result), 64'(sq_result));

    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        rsp_cnt[i]++;
        tot_del++;
      end
    end
    if (sq_valid && sq_ready) begin
      tot_iss++;
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    end

    // Reference: retire oldest outstanding, check its value reached the owner.
    if (rst_n && sq_res_valid && exp_srr) begin
      e = pend_q.pop_front();
      chk("rsp_owner", 64'(rsp_valid[e.id] && rsp_ready[e.id]), 64'(1));
      chk_sqrt("rsp_value", rsp_result, e.a);
    end
    if (exp_sv && sq_ready) begin
      pend_q.push_back('{id: g, a: op[g]});
      rr = (g + 1) % N;
      if (refresh) op[g] = rand_op();
    end
    if (rst_n && sq_res_valid && empty) orphan_exp = 1'b1;

    // fxSqrt model reacts to the actual wire handshakes.
    if (sq_res_valid && sq_res_ready && pipe_res.size() > 0) begin
      void'(pipe_res.pop_front());
      void'(pipe_age.pop_front());
    end
    foreach (pipe_age[i]) pipe_age[i]++;
    if (sq_valid && sq_ready) begin
      pipe_res.push_back(isqrt_q16(sq_a));
      pipe_age.push_back(0);
    end

    @(posedge clk);
    if (!rst_n) begin
      pend_q.delete();
      pipe_res.delete();
      pipe_age.delete();
      rr = 0;
      orphan_exp = 1'b0;
    end
    @(negedge clk);
    sq_res_valid = (pipe_res.size() > 0) && (pipe_age[0] >= LAT);
    sq_result    = sq_res_valid ? pipe_res[0] : 32'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    rsp_ready = '1;
    sq_ready  = 1'b1;
    n = 0;
    while ((pend_q.size() != 0 || pipe_res.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(pend_q.size()), 64'(0));
  endtask

  initial begin
    int iss0, del0, n, c0;
    compared = 0; mismatched = 0; tot_iss = 0; tot_del = 0;
    rr = 0; orphan_exp = 1'b0; refresh = 1'b0;
    foreach (rsp_cnt[i]) rsp_cnt[i] = 0;
    foreach (op[i]) op[i] = '0;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; sq_ready = 1'b0;
    sq_res_valid = 1'b0; sq_result = '0; req_a = '0;

    // Reset: outputs quiet while asserted.
    tick();
    req_valid = '1; sq_ready = 1'b1; rsp_ready = '1;
    tick();
    chk("rst_req_ready", 64'(obs_req_ready), 64'(0));
    chk("rst_sq_valid", 64'(obs_sq_valid), 64'(0));
    rst_n = 1'b1; req_valid = '0;

    // Single requester: sqrt(4.0) = 2.0, one pulse back to requester 0.
    op[0] = 32'h0004_0000;
    c0 = rsp_cnt[0];
    req_valid = 4'b0001;
    tick();
    chk("p1_inflight_before", 64'(obs_inflight), 64'(0));
    req_valid = '0;
    tick();
    chk("p1_inflight_during", 64'(obs_inflight), 64'(1));
    drain();
    chk("p1_pulses", 64'(rsp_cnt[0] - c0), 64'(1));

    // All four hold valid from rr_ptr=0: grants 0,1,2,3,0,1,2,3.
    do_reset();
    op[0] = 32'h0001_0000; op[1] = 32'h0004_0000; op[2] = 32'h0009_0000; op[3] = 32'h0010_0000;
    grant_log.delete();
    req_valid = '1;
    repeat (8) tick();
    chk("p2_ngrants", 64'(grant_log.size()), 64'(8));
    for (int k = 0; k < grant_log.size(); k++) chk("p2_grant", 64'(grant_log[k]), 64'(k % 4));
    drain();

    // Fairness between requesters 0 and 2.
    refresh = 1'b1;
    grant_log.delete();
    req_valid = 4'b0101;
    n = 0;
    while (grant_log.size() < 20 && n < 100) begin
      tick();
      n++;
    end
    chk("p3_ngrants", 64'(grant_log.size() >= 20), 64'(1));
    for (int k = 1; k < grant_log.size(); k++) begin
      chk("p3_alternate", 64'(grant_log[k] != grant_log[k-1]), 64'(1));
    end
    drain();

    // Full: no results accepted, occupancy saturates, then recovers without loss.
    iss0 = tot_iss; del0 = tot_del;
    rsp_ready = '0; req_valid = '1; sq_ready = 1'b1;
    repeat (24) tick();
    chk("p4_inflight_full", 64'(obs_inflight), 64'(16));
    chk("p4_req_ready_full", 64'(obs_req_ready), 64'(0));
    chk("p4_sq_valid_full", 64'(obs_sq_valid), 64'(0));
    rsp_ready = '1;
    repeat (12) tick();
    drain();
    chk("p4_no_loss", 64'(tot_del - del0), 64'(tot_iss - iss0));

    // Back-pressure: requester 1 stalls its result, requester 2 must wait behind it.
    refresh = 1'b0;
    op[1] = 32'h0019_0000; op[2] = 32'h0024_0000;
    rsp_ready = 4'b1101;
    req_valid = 4'b0010; tick();
    req_valid = 4'b0100; tick();
    req_valid = '0;
    n = 0;
    while (!(sq_res_valid && pend_q.size() > 0 && pend_q[0].id == 1) && n < 20) begin
      tick();
      n++;
    end
    chk("p5_head_arrived", 64'(n < 20), 64'(1));
    tick();
    c0 = rsp_cnt[2];
    for (int k = 0; k < 5; k++) begin
      logic [W-1:0] held;
      held = obs_rsp_result;
      tick();
      chk("p5_stable", 64'(obs_rsp_result), 64'(held));
      chk("p5_rsp_valid", 64'(obs_rsp_valid), 64'(4'b0010));
      chk("p5_sq_res_ready", 64'(obs_sq_res_ready), 64'(0));
    end
    chk("p5_no_early", 64'(rsp_cnt[2] - c0), 64'(0));
    drain();

    // Reset mid-burst with six outstanding, then an orphan result.
    rsp_ready = '0; req_valid = '1; sq_ready = 1'b1;
    n = 0;
    while (pend_q.size() != 6 && n < 30) begin
      tick();
      n++;
    end
    chk("p6_six_inflight", 64'(pend_q.size()), 64'(6));
    rst_n = 1'b0;
    tick();
    chk("p6_rst_inflight", 64'(obs_inflight), 64'(0));
    chk("p6_rst_rsp_valid", 64'(obs_rsp_valid), 64'(0));
    rst_n = 1'b1; req_valid = '0; rsp_ready = '1;
    tick();
    chk("p6_post_inflight", 64'(obs_inflight), 64'(0));
    repeat (6) tick();
    sq_res_valid = 1'b1; sq_result = 32'hDEAD_BEEF;
    tick();
    chk("p6_orphan_not_taken", 64'(obs_sq_res_ready), 64'(0));
    sq_res_valid = 1'b0;
    tick();
    chk("p6_err_orphan", 64'(obs_err_orphan), 64'(1));

    // Random traffic.
    do_reset();
    refresh = 1'b1;
    foreach (op[i]) op[i] = rand_op();
    iss0 = tot_iss; del0 = tot_del;
    for (int k = 0; k < 600; k++) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom) | N'($urandom);
      sq_ready  = ($urandom_range(0, 4) != 0);
      tick();
    end
    drain();
    chk("rand_no_loss", 64'(tot_del - del0), 64'(tot_iss - iss0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fx_sqrt_arbiter.md
Name: fx_sqrt_arbiter

Overview:
Shares one fxSqrt instance between N_REQ independent requesters, such as per-path LSM regression lanes and QMC transform stages.
- Arbitration: round-robin on the issue side.
- Routing: a requester-ID tag FIFO, tracking every operand in flight, steers each in-order result back to its originator.
- Position: sits between the requesters and the fxSqrt valid/ready ports, and adds no cycles on either path.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, fpga_cfg_pkg::FP_WIDTH, fixed-point word width
MAX_INFLIGHT, 16, tag FIFO depth = max outstanding sqrt ops (power of 2, must be >= FP_SQRT_LATENCY+2)
ID_W, $clog2(N_REQ), tag width (derived, localparam)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  N_REQ  per-requester operand valid
req_ready  out  N_REQ  per-requester accept
req_a  in  N_REQ*WIDTH  operands, requester i at bits [i*WIDTH +: WIDTH]
rsp_valid  out  N_REQ  per-requester result valid
rsp_ready  in  N_REQ  per-requester result accept
rsp_result  out  WIDTH  result, broadcast to all requesters, qualified by rsp_valid
sq_valid  out  1  to fxSqrt valid_in
sq_ready  in  1  from fxSqrt ready_out
sq_a  out  WIDTH  to fxSqrt a
sq_res_valid  in  1  from fxSqrt valid_out
sq_res_ready  out  1  to fxSqrt ready_in
sq_result  in  WIDTH  from fxSqrt result
inflight  out  $clog2(MAX_INFLIGHT+1)  current tag FIFO occupancy
err_orphan  out  1  sticky: a result arrived while the tag FIFO was empty

Behaviour:
- Reset: clk only; synchronous, active-low on rst_n.
  - Clears the tag FIFO pointers and count, sets rr_ptr=0, and clears err_orphan.
  - In the reset cycle, every output is 0 (req_ready, rsp_valid, sq_valid, sq_res_ready, inflight, err_orphan). rsp_result and sq_a are don't-care.
  - fxSqrt shares rst_n, so a mid-operation reset discards all in-flight ops. No response is produced for them.
- Issue path (combinational, 0 added latency):
  - full = (count == MAX_INFLIGHT).
  - grant = first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - sq_valid = |req_valid && !full.
  - sq_a = req_a[grant].
  - req_ready[i] = (i == grant) && sq_ready && !full; all other bits are 0.
  - req_ready never depends on the requester's own req_valid beyond grant selection.
- Issue handshake: issue = sq_valid && sq_ready. On issue:
  - push grant into the tag FIFO;
  - rr_ptr <= (grant+1) mod N_REQ.
  - With no issue, rr_ptr holds. A requester that keeps req_valid asserted waits at most N_REQ-1 grants.
- Response path (combinational):
  - head = tag FIFO head; empty = (count == 0).
  - rsp_valid[i] = sq_res_valid && !empty && (head == i).
  - rsp_result = sq_result.
  - sq_res_ready = empty ? 0 : rsp_ready[head].
  - The rsp_valid, rsp_result and sq_res_ready formulas carry no combinational path from req_* or sq_ready.
- Response handshake: retire = sq_res_valid && sq_res_ready, which pops the head.
  - A stalled requester back-pressures the shared fxSqrt, by design. Results are strictly in issue order.
- Simultaneous issue and retire in one cycle: count is unchanged and both pointers advance. Push is allowed when full only if a retire happens in the same cycle? No: full blocks issue regardless (full is a registered-state condition). This avoids a sq_ready→rsp_ready combinational loop.
- Pointer and count width rules:
  - Wrap-around: wr_ptr and rd_ptr are $clog2(MAX_INFLIGHT) bits and wrap naturally.
  - count is a separate counter, 0..MAX_INFLIGHT. inflight = count.
- Orphan results:
  - If sq_res_valid is asserted while empty, set err_orphan (sticky until reset).
  - sq_res_ready stays 0; the result is not consumed and no rsp_valid is raised.
- Stability: while rsp_valid[i] && !rsp_ready[i], head and rsp_result are held stable. This relies on the fxSqrt stall-stable guarantee; no extra register is needed.

Test Plan:
1. Single requester, WIDTH=32, QFRAC=16: req 0 sends 0x0004_0000 (4.0) -> exactly one rsp_valid[0] pulse, rsp_result 0x0002_0000 ±1 LSB; inflight goes 0→1→0.
2. All 4 requesters hold valid with operands 1.0, 4.0, 9.0, 16.0 from rr_ptr=0 -> grants in order 0,1,2,3,0,... one per cycle. Results return to 0..3 as 1.0, 2.0, 3.0, 4.0 ±1 LSB, in order.
3. Fairness: req 0 and req 2 hold valid continuously for 20 issues -> grants alternate 0,2,0,2; neither gets two consecutive grants while the other waits.
4. Full: hold rsp_ready=0 on all requesters and issue continuously -> inflight saturates at 16 and req_ready goes 0. Then release rsp_ready -> issue resumes with no lost or duplicated results.
5. Back-pressure: requester 1's result is at head with rsp_ready[1]=0 for 5 cycles -> sq_res_ready=0, rsp_result is stable, and requester 2's later result is not delivered early.
6. Reset mid-burst: assert rst_n=0 with inflight=6 -> the next cycle all outputs are 0 and inflight=0. No rsp_valid from pre-reset ops. An injected sq_res_valid with an empty FIFO sets err_orphan=1.
